// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: controller/memory side (master) and fetch unit (slave).
// The fetch-count signal exists only when IFETCH_CNT_EN is defined.
interface instr_fetch_unit_if;
  logic        stall_i;
  logic        flush_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic [31:0] instr_i;
  logic [31:0] instr_addr_o;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc4_o;
  logic        ifid_valid_o;
`ifdef IFETCH_CNT_EN
  logic [31:0] ifetch_cnt_o;

  modport master (
    output stall_i, flush_i, branch_i, branch_addr_i, instr_i,
    input  instr_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o, ifetch_cnt_o
  );
  modport slave (
    input  stall_i, flush_i, branch_i, branch_addr_i, instr_i,
    output instr_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o, ifetch_cnt_o
  );
`else
  modport master (
    output stall_i, flush_i, branch_i, branch_addr_i, instr_i,
    input  instr_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o
  );
  modport slave (
    input  stall_i, flush_i, branch_i, branch_addr_i, instr_i,
    output instr_addr_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o
  );
`endif
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: word-aligned PC register plus the IF/ID pipeline register.
// Optional saturating fetch counter is compiled in when IFETCH_CNT_EN is defined.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk_i,
  input logic               rst_i,
  instr_fetch_unit_if.slave bus
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_instr_reg;
  logic [31:0] ifid_pc4_reg;
  logic        ifid_valid_reg;
  logic        ifid_load;

  // Wraps modulo 2^32; low bits stay zero because every PC source is masked.
  assign pc_plus4  = pc_reg + 32'd4;
  assign ifid_load = !bus.flush_i && !bus.stall_i;

  // A redirect wins over a stall so a taken branch is never lost.
  always_comb begin
    pc_next = pc_plus4;
    if (bus.branch_i) begin
      pc_next = bus.branch_addr_i & ALIGN_MASK;
    end else if (bus.stall_i) begin
      pc_next = pc_reg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_reg <= RESET_PC & ALIGN_MASK;
    end else begin
      pc_reg <= pc_next;
    end
  end

  // Flush beats stall; a branch alone still loads the sequential word.
  always_ff @(posedge clk_i) begin
    if (!rst_i || bus.flush_i) begin
      ifid_instr_reg <= 32'h0;
      ifid_pc4_reg   <= 32'h0;
      ifid_valid_reg <= 1'b0;
    end else if (!bus.stall_i) begin
      ifid_instr_reg <= bus.instr_i;
      ifid_pc4_reg   <= pc_plus4;
      ifid_valid_reg <= 1'b1;
    end
  end

  assign bus.instr_addr_o = pc_reg;
  assign bus.ifid_instr_o = ifid_instr_reg;
  assign bus.ifid_pc4_o   = ifid_pc4_reg;
  assign bus.ifid_valid_o = ifid_valid_reg;

`ifdef IFETCH_CNT_EN
  logic [31:0] ifetch_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ifetch_cnt_reg <= 32'h0;
    end else if (ifid_load && (ifetch_cnt_reg != 32'hFFFF_FFFF)) begin
      ifetch_cnt_reg <= ifetch_cnt_reg + 32'd1;
    end
  end

  assign bus.ifetch_cnt_o = ifetch_cnt_reg;
`endif

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: stall_i  input  1  hold PC and IF/ID register (hazard stall).
REQ-005 SHALL have port: flush_i  input  1  squash IF/ID contents to bubble.
REQ-006 SHALL have port: branch_i  input  1  redirect PC to branch_addr_i.
REQ-007 SHALL have port: branch_addr_i  input  32  redirect target byte address.
REQ-008 SHALL have port: instr_i  input  32  word returned by instruction memory for instr_addr_o, same cycle.
REQ-009 SHALL have port: instr_addr_o  output  32  byte address to instruction memory (current PC).
REQ-010 SHALL have port: ifid_instr_o  output  32  registered instruction to decode.
REQ-011 SHALL have port: ifid_pc4_o  output  32  registered PC+4 of that instruction.
REQ-012 SHALL have port: ifid_valid_o  output  1  IF/ID holds a real instruction.
REQ-013 SHALL have port: ifetch_cnt_o  output  32  fetched-instruction count; present only per REQ-030.

Function
REQ-014 SHALL drive instr_addr_o directly from the PC register, no combinational path from any input.
REQ-015 SHALL, per cycle, update PC with priority: branch_i -> {branch_addr_i[31:2],2'b00}; else stall_i -> hold; else PC+4.
REQ-016 SHALL apply branch_i even while stall_i is high (redirect never lost).
REQ-017 SHALL force PC[1:0] to 2'b00 at all times; misaligned targets are truncated, not trapped.
REQ-018 SHALL compute PC+4 modulo 2^32; PC 32'hFFFF_FFFC increments to 32'h0000_0000.
REQ-019 SHALL update IF/ID with priority: flush_i -> instr 32'h0, pc4 32'h0, valid 0; else stall_i -> hold all three; else load instr_i, PC+4, valid 1.
REQ-020 SHALL let flush_i override stall_i on the IF/ID register; stall_i does not block flush.
REQ-021 SHALL present the word at address A on ifid_instr_o exactly one cycle after instr_addr_o equals A (latency 1).
REQ-022 SHALL treat a cycle with branch_i high and flush_i low as a normal IF/ID load of the sequential word; squashing it is the controller's job via flush_i.
REQ-023 SHALL, while stall_i is held N cycles with no branch/flush, keep all outputs constant for those N cycles.

Reset
REQ-024 SHALL, when rst_i is low at a rising edge, set PC to RESET_PC with bits [1:0] cleared.
REQ-025 SHALL, on reset, set ifid_instr_o = 32'h0, ifid_pc4_o = 32'h0, ifid_valid_o = 0.
REQ-026 SHALL give reset priority over branch_i, stall_i and flush_i.
REQ-027 SHALL, on reset asserted mid-stream, discard any in-flight IF/ID contents at that edge.
REQ-028 SHALL produce the first valid IF/ID entry (instruction at RESET_PC) on the first edge after rst_i returns high, given no stall/flush.

Configuration
REQ-029 SHALL compile the fetch counter only when macro IFETCH_CNT_EN is defined.
REQ-030 SHALL, with IFETCH_CNT_EN: increment ifetch_cnt_o on every edge where IF/ID loads with valid 1; saturate at 32'hFFFF_FFFF; reset to 0; hold on stall/flush.
REQ-031 SHALL, without IFETCH_CNT_EN: omit port ifetch_cnt_o and the counter register; all other behaviour unchanged.

Verification
REQ-032 SHALL cover: reset, RESET_PC=0, memory words 0..3 = 32'h11,22,33,44, no stall -> instr_addr_o 0,4,8,12; ifid_instr_o 0x11,0x22,0x33 one cycle behind; ifid_pc4_o 4,8,12; valid rises on first post-reset edge.
REQ-033 SHALL cover: stall_i high 3 cycles with PC=8 -> instr_addr_o stays 8, IF/ID holds 0x22/pc4 8 for 3 cycles, then 0x33 loads.
REQ-034 SHALL cover: branch_i=1, branch_addr_i=32'h0000_0042 with stall_i=1 and flush_i=1 -> next PC 32'h40, IF/ID = 0/0/valid 0.
REQ-035 SHALL cover: PC=32'hFFFF_FFFC, no stall -> next instr_addr_o 32'h0, ifid_pc4_o 32'h0, valid 1.
REQ-036 SHALL cover: rst_i low mid-stream with stall_i=1 -> PC=RESET_PC, IF/ID cleared, counter (IFETCH_CNT_EN) 0; run 5 unstalled cycles -> ifetch_cnt_o = 5.
